// File: rtl/aes256_pkg.sv
// aes256_pkg: shared AES-256 byte/row/state types and the InvShiftRows FSM encoding. Rev 1.0
`default_nettype none

package aes256_pkg;
  localparam int N  = 4;
  localparam int BW = 8;

  typedef logic [BW-1:0]         aes_byte_t;
  typedef aes_byte_t [N-1:0]     aes_row_t;
  typedef aes_byte_t [N*N-1:0]   aes_state_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    OUT   = 2'd2
  } dec_shift_state_t;
endpackage

`default_nettype wire

// File: rtl/mod_dec_rowrot.sv
// mod_dec_rowrot: rotates one state row right by its 2-bit row index (inverse ShiftRows). Rev 1.0
`default_nettype none

module mod_dec_rowrot
  import aes256_pkg::*;
(
  input  aes_row_t   row_i,
  input  logic [1:0] idx_i,
  output aes_row_t   row_o
);

  for (genvar c = 0; c < 4; c++) begin : g_col
    localparam logic [1:0] C_COL = 2'(c);
    // 2-bit subtraction wraps, giving (c - idx) mod 4 for free
    assign row_o[c] = row_i[C_COL - idx_i];
  end

endmodule

`default_nettype wire

// File: rtl/mod_dec_invshifter.sv
// mod_dec_invshifter: decrypt-side InvShiftRows, captures a state and rotates one row per clock. Rev 1.0
`default_nettype none

module mod_dec_invshifter
  import aes256_pkg::*;
#(
  parameter int N  = 4,
  parameter int BW = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [N*N-1:0][BW-1:0]    inp,
  input  logic                      in_valid,
  output logic                      in_ready,
  output logic [N*N-1:0][BW-1:0]    outp,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic                      done
);

  dec_shift_state_t state_q, state_d;
  logic [1:0]       row_cnt_q, row_cnt_d;
  aes_state_t       in_q, in_d;
  aes_state_t       out_q, out_d;
  logic             done_q, done_d;
  aes_row_t         w_row;
  aes_row_t         w_rot;

  assign w_row = in_q[{row_cnt_q, 2'b00} +: 4];

  mod_dec_rowrot u_rowrot (
    .row_i (w_row),
    .idx_i (row_cnt_q),
    .row_o (w_rot)
  );

  always_comb begin
    state_d   = state_q;
    row_cnt_d = row_cnt_q;
    in_d      = in_q;
    out_d     = out_q;
    done_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          in_d      = inp;
          row_cnt_d = 2'd0;
          state_d   = SHIFT;
        end
      end
      SHIFT: begin
        out_d[{row_cnt_q, 2'b00} +: 4] = w_rot;
        row_cnt_d = row_cnt_q + 2'd1;
        if (row_cnt_q == 2'd3) begin
          state_d = OUT;
        end
      end
      OUT: begin
        if (out_ready) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      row_cnt_q <= 2'd0;
      in_q      <= '0;
      out_q     <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      row_cnt_q <= row_cnt_d;
      in_q      <= in_d;
      out_q     <= out_d;
      done_q    <= done_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == OUT);
  assign outp      = out_q;
  assign done      = done_q;

endmodule

`default_nettype wire

// File: tb/tb_mod_dec_invshifter.sv
// tb_mod_dec_invshifter: scoreboard bench for the InvShiftRows stage. Rev 1.0
`default_nettype none

module tb_mod_dec_invshifter;
  import aes256_pkg::*;

  logic       clk;
  logic       rst_n;
  aes_state_t inp;
  logic       in_valid;
  logic       in_ready;
  aes_state_t outp;
  logic       out_valid;
  logic       out_ready;
  logic       done;

  int n_checks = 0;
  int n_errors = 0;
  aes_state_t sb_q[$];

  mod_dec_invshifter #(.N(4), .BW(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .inp       (inp),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .outp      (outp),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic aes_state_t inv_ref(aes_state_t s);
    aes_state_t o;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        o[4*r+c] = s[4*r + ((c - r + 4) % 4)];
    return o;
  endfunction

  function automatic aes_state_t enc_shift(aes_state_t s);
    aes_state_t o;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        o[4*r+c] = s[4*r + ((c + r) % 4)];
    return o;
  endfunction

  function automatic aes_state_t rand_state();
    aes_state_t s;
    for (int i = 0; i < 16; i++) s[i] = 8'($urandom);
    return s;
  endfunction

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Waits for in_ready, presents s for one accept edge, pushes the expectation.
  task automatic send(input aes_state_t s, input aes_state_t exp);
    int budget = 20;
    @(negedge clk);
    while (!in_ready && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    if (!in_ready) begin
      n_checks++; n_errors++;
      $display("FAIL send_timeout: in_ready got 0 expected 1");
    end
    inp = s;
    in_valid = 1'b1;
    sb_q.push_back(exp);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_out(output bit ok);
    int budget = 20;
    while (!out_valid && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    ok = out_valid;
    if (!ok) begin
      n_checks++; n_errors++;
      $display("FAIL out_timeout: out_valid got 0 expected 1");
    end
  endtask

  task automatic check_and_finish(input string name);
    aes_state_t exp;
    exp = (sb_q.size() > 0) ? sb_q.pop_front() : '0;
    n_checks++;
    if (outp !== exp) begin
      n_errors++;
      $display("FAIL %s: outp got %h expected %h", name, outp, exp);
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk({name, "_done"}, 128'(done), 128'(1));
    chk({name, "_ovalid_drop"}, 128'(out_valid), 128'(0));
    chk({name, "_iready"}, 128'(in_ready), 128'(1));
    out_ready = 1'b0;
    @(negedge clk);
    chk({name, "_done_once"}, 128'(done), 128'(0));
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    @(negedge clk);
    chk("rst_outp", outp, '0);
    chk("rst_ovalid", 128'(out_valid), 128'(0));
    chk("rst_done", 128'(done), 128'(0));
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_iready", 128'(in_ready), 128'(1));
    chk("rst_ovalid_after", 128'(out_valid), 128'(0));
  endtask

  task automatic test_basic();
    aes_state_t s, e;
    bit ok;
    for (int i = 0; i < 16; i++) s[i] = 8'(i);
    e = {8'h0C, 8'h0F, 8'h0E, 8'h0D, 8'h09, 8'h08, 8'h0B, 8'h0A,
         8'h06, 8'h05, 8'h04, 8'h07, 8'h03, 8'h02, 8'h01, 8'h00};
    send(s, e);
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      chk($sformatf("basic_latency_%0d", k), 128'(out_valid), 128'(0));
    end
    @(negedge clk);
    chk("basic_latency_4", 128'(out_valid), 128'(1));
    wait_out(ok);
    if (ok) check_and_finish("basic");
  endtask

  task automatic test_roundtrip();
    aes_state_t s;
    bit ok;
    int bad = 0;
    for (int v = 0; v < 1000; v++) begin
      s = rand_state();
      send(enc_shift(s), s);
      wait_out(ok);
      if (ok) begin
        n_checks++;
        if (outp !== sb_q[0]) begin
          n_errors++;
          if (bad < 5) $display("FAIL roundtrip_%0d: outp got %h expected %h", v, outp, sb_q[0]);
          bad++;
        end
        void'(sb_q.pop_front());
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
      end else begin
        sb_q.delete();
      end
    end
  endtask

  task automatic test_backpressure();
    aes_state_t s;
    bit ok;
    s = rand_state();
    send(s, inv_ref(s));
    wait_out(ok);
    if (ok) begin
      for (int k = 0; k < 10; k++) begin
        chk("bp_outp", outp, sb_q[0]);
        chk("bp_ovalid", 128'(out_valid), 128'(1));
        chk("bp_done", 128'(done), 128'(0));
        @(negedge clk);
      end
      check_and_finish("bp");
    end
  endtask

  task automatic test_busy_reject();
    aes_state_t s;
    bit ok;
    s = rand_state();
    send(s, inv_ref(s));
    chk("busy_iready", 128'(in_ready), 128'(0));
    inp = {16{8'hFF}};
    in_valid = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    chk("busy_iready2", 128'(in_ready), 128'(0));
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b0;
    wait_out(ok);
    if (ok) check_and_finish("busy");
  endtask

  task automatic test_reset_mid();
    aes_state_t s;
    bit ok;
    s = rand_state();
    send(s, inv_ref(s));
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rmid_ovalid", 128'(out_valid), 128'(0));
    chk("rmid_done", 128'(done), 128'(0));
    chk("rmid_outp", outp, '0);
    sb_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rmid_iready", 128'(in_ready), 128'(1));
    s = rand_state();
    send(s, inv_ref(s));
    wait_out(ok);
    if (ok) check_and_finish("rmid_new");
  endtask

  task automatic test_back_to_back();
    aes_state_t st[3];
    int k = 0, n_done = 0, n_out = 0, cyc = 0;
    int done_cyc[3];
    for (int i = 0; i < 3; i++) st[i] = rand_state();
    out_ready = 1'b1;
    while (n_done < 3 && cyc < 60) begin
      @(negedge clk);
      cyc++;
      if (done) begin
        done_cyc[n_done] = cyc;
        n_done++;
      end
      if (out_valid) begin
        chk($sformatf("b2b_out_%0d", n_out), outp, (sb_q.size() > 0) ? sb_q[0] : '0);
        if (sb_q.size() > 0) void'(sb_q.pop_front());
        n_out++;
      end
      if (k < 3) begin
        inp = st[k];
        in_valid = 1'b1;
        if (in_ready) begin
          sb_q.push_back(inv_ref(st[k]));
          k++;
        end
      end else begin
        in_valid = 1'b0;
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    chk("b2b_ndone", 128'(n_done), 128'(3));
    chk("b2b_nout", 128'(n_out), 128'(3));
    if (n_done == 3) begin
      chk("b2b_gap1", 128'(done_cyc[1] - done_cyc[0]), 128'(6));
      chk("b2b_gap2", 128'(done_cyc[2] - done_cyc[1]), 128'(6));
    end
  endtask

  initial begin
    rst_n = 1'b0;
    inp = '0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    test_reset();
    test_basic();
    test_roundtrip();
    test_backpressure();
    test_busy_reject();
    test_reset_mid();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mod_dec_invshifter.md
Name: mod_dec_invshifter

Overview:
- Decryption-side InvShiftRows stage for the AES-256 core; the inverse of the encryption row shifter.
- Accepts a full 16-byte state via a valid/ready handshake and rotates each row right by its row index, one row per clock.
- Presents the complete result state with out_valid until the downstream stage accepts it.
- Sits in the decrypt round datapath between the AddRoundKey/InvMixColumns stage and InvSubBytes.

Parameters:
- N, 4, bytes per row and number of rows. Fixed at 4 for AES; not intended to be overridden.
- BW, 8, bits per byte.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- inp  input  [N*N-1:0][BW-1:0]  input state; byte index = 4*row + col, so row r is inp[4r+3:4r]
- in_valid  input  1  inp is valid this cycle
- in_ready  output  1  block can accept a state
- outp  output  [N*N-1:0][BW-1:0]  shifted state, same byte layout as inp
- out_valid  output  1  outp holds a complete result
- out_ready  input  1  downstream accepts outp
- done  output  1  one-cycle pulse on the output handshake

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=IDLE, row_cnt=0, input register=0, outp=0.
  - out_valid=0, done=0, in_ready=1 once rst_n is released.
- Rotation rule: outp[4r+c] = inp[4r+((c-r) mod 4)]; row 0 is unchanged, row 1 rotates right by 1, row 2 by 2, row 3 by 3. Index arithmetic is 2-bit and wraps naturally.
- FSM states: IDLE, SHIFT, OUT.
- IDLE:
  - in_ready=1.
  - On in_valid at a clock edge: capture inp into the input register, clear row_cnt to 0, go to SHIFT.
- SHIFT:
  - in_ready=0.
  - Each edge writes rotated row row_cnt into the output register, then increments row_cnt.
  - After the edge that writes row 3, row_cnt wraps to 0 and the state goes to OUT.
- OUT:
  - out_valid=1; outp and all internal registers are held stable.
  - On out_ready at an edge: done=1 for exactly one cycle, out_valid drops, state goes to IDLE.
- Latency: out_valid is asserted 4 edges after the accept edge. Minimum initiation interval is 6 cycles (accept, 4 SHIFT, OUT with out_ready high).
- Boundary conditions:
  - in_valid while in SHIFT or OUT is ignored; in_ready is low and no capture happens.
  - out_ready held low: the block stays in OUT indefinitely with outp unchanged.
  - out_ready high outside OUT has no effect.
  - in_valid and out_ready high together in OUT: only the output handshake completes. The new input can be accepted on the next cycle in IDLE.
  - The input register is captured only on the accept edge, so changes on inp during SHIFT do not affect the result.
  - Reset mid-SHIFT or mid-OUT aborts the operation with no done pulse; all outputs return to reset values immediately.
- Output-register rows not yet written during SHIFT are don't-care to consumers, since out_valid=0.

Decomposition:
- Shared package aes256_pkg:
  - constants N=4, BW=8;
  - typedefs aes_byte_t, aes_row_t ([3:0] bytes), aes_state_t ([15:0] bytes);
  - enum dec_shift_state_t {IDLE, SHIFT, OUT}.
- One combinational sub-module, mod_dec_rowrot: takes a row and a 2-bit row index, returns the right-rotated row. It is the exact inverse of the encryption row shifter and is reused by any single-row inverse path.
- The FSM, row counter and registers stay in mod_dec_invshifter.

Test Plan:
- Basic: inp bytes 0x00..0x0F (byte i = i), in_valid for one cycle -> after 4 edges out_valid=1 and rows read [00,01,02,03], [07,04,05,06], [0A,0B,08,09], [0D,0E,0F,0C]. With out_ready=1, done pulses once and in_ready returns to 1 on the next cycle.
- Round trip: random state -> encryption shifter applied per row -> this block gives back the original state bit-exact over 1000 random vectors.
- Backpressure: out_ready=0 for 10 cycles after out_valid -> outp and out_valid are stable each cycle and done=0; raising out_ready gives one done pulse.
- Busy-input rejection: second in_valid with a different state (all 0xFF) during SHIFT -> in_ready=0, no capture, result still matches the first state.
- Reset mid-operation: drop rst_n on the 2nd SHIFT cycle -> out_valid=0, done=0, outp=0 immediately. After release in_ready=1 and a new transaction completes correctly.
- Back-to-back: 3 states presented as soon as in_ready is high -> 3 done pulses spaced 6 cycles apart, each output correct and in order.
